// File: rtl/packet_pkg.sv
// Shared packet types and helpers for the switch port traffic sources.
package packet_pkg;

  localparam int ADDR_WIDTH    = 4;
  localparam int PKT_PAYLOAD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  // Canonical request layout for the default payload width.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    target;
    logic [PKT_PAYLOAD_W-1:0] data;
  } tx_req_t;

  function automatic logic is_onehot(input logic [ADDR_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ADDR_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is visible on rdata while not empty.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/switch_port_tx.sv
// Per-port packet source: checks and queues host requests, then emits single-beat
// packets toward one switch port with a fixed inter-packet gap.
module switch_port_tx
  import packet_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int DEPTH      = 4,
  parameter int PAYLOAD_W  = 8,
  parameter int GAP        = 1,
  parameter int ALLOW_SELF = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_target,
  input  logic [PAYLOAD_W-1:0]  req_data,
  output logic                  valid_in,
  output logic [ADDR_WIDTH-1:0] source_in,
  output logic [ADDR_WIDTH-1:0] target_in,
  output logic [PAYLOAD_W-1:0]  data_in,
  output logic                  busy,
  output logic [15:0]           sent_cnt,
  output logic [7:0]            drop_cnt,
  output logic [1:0]            dbg_state
);

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both 1; req_ready is a register that is 1 exactly when the
  // FIFO has room, so a full FIFO never accepts even when it pops that cycle.

  localparam int FW = ADDR_WIDTH + PAYLOAD_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] OWN_BIT = ADDR_WIDTH'(1 << PORT_ID);

  tx_state_e         state, state_next;
  logic [GW-1:0]     gap_cnt, gap_next;
  logic              accept, legal, push, pop, drop, can_pop;
  logic [FW-1:0]     head;
  logic              full, empty;
  logic [CW-1:0]     count, count_next;

  assign accept = req_valid && req_ready;
  assign legal  = is_onehot(req_target) &&
                  ((ALLOW_SELF != 0) || ((req_target & OWN_BIT) == '0));
  assign push   = accept && legal;
  assign drop   = accept && !legal;

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({req_target, req_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign can_pop = enable && !empty;

  // An expired gap behaves like IDLE so GAP=N leaves exactly N idle cycles.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (GAP > 0) begin
          state_next = packet_pkg::GAP;
          gap_next   = GW'(GAP - 1);
        end else if (can_pop) begin
          pop        = 1'b1;
          state_next = SEND;
        end else begin
          state_next = IDLE;
        end
      end
      packet_pkg::GAP: begin
        if (gap_cnt == '0) begin
          if (can_pop) begin
            pop        = 1'b1;
            state_next = SEND;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_next = gap_cnt - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      valid_in  <= 1'b0;
      source_in <= '0;
      target_in <= '0;
      data_in   <= '0;
      sent_cnt  <= '0;
      drop_cnt  <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      gap_cnt   <= gap_next;
      valid_in  <= pop;
      source_in <= pop ? OWN_BIT : '0;
      target_in <= pop ? head[FW-1:PAYLOAD_W] : '0;
      data_in   <= pop ? head[PAYLOAD_W-1:0] : '0;
      sent_cnt  <= sent_cnt + 16'(pop);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      req_ready <= (count_next != CW'(DEPTH));
    end
  end

  assign busy      = !empty || (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_switch_port_tx.sv
// Bench for switch_port_tx: a GAP=1 and a GAP=0 instance on port 1, directed requests,
// expected packets queued per instance and checked by negedge monitors.
module tb_switch_port_tx;

  localparam logic [3:0] OWN = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: GAP=1, instance B: GAP=0
  logic        a_enable = 0, a_valid = 0;
  logic [3:0]  a_target = 0;
  logic [7:0]  a_data = 0;
  logic        a_req_ready, a_valid_in, a_busy;
  logic [3:0]  a_source_in, a_target_in;
  logic [7:0]  a_data_in, a_drop_cnt;
  logic [15:0] a_sent_cnt;
  logic [1:0]  a_state;

  logic        b_enable = 0, b_valid = 0;
  logic [3:0]  b_target = 0;
  logic [7:0]  b_data = 0;
  logic        b_req_ready, b_valid_in, b_busy;
  logic [3:0]  b_source_in, b_target_in;
  logic [7:0]  b_data_in, b_drop_cnt;
  logic [15:0] b_sent_cnt;
  logic [1:0]  b_state;

  switch_port_tx #(.PORT_ID(1), .DEPTH(4), .PAYLOAD_W(8), .GAP(1), .ALLOW_SELF(0)) dut_a (
    .clk(clk), .rst(rst), .enable(a_enable), .req_valid(a_valid), .req_ready(a_req_ready),
    .req_target(a_target), .req_data(a_data), .valid_in(a_valid_in), .source_in(a_source_in),
    .target_in(a_target_in), .data_in(a_data_in), .busy(a_busy), .sent_cnt(a_sent_cnt),
    .drop_cnt(a_drop_cnt), .dbg_state(a_state)
  );

  switch_port_tx #(.PORT_ID(1), .DEPTH(4), .PAYLOAD_W(8), .GAP(0), .ALLOW_SELF(0)) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .req_valid(b_valid), .req_ready(b_req_ready),
    .req_target(b_target), .req_data(b_data), .valid_in(b_valid_in), .source_in(b_source_in),
    .target_in(b_target_in), .data_in(b_data_in), .busy(b_busy), .sent_cnt(b_sent_cnt),
    .drop_cnt(b_drop_cnt), .dbg_state(b_state)
  );

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  bit spacing_on = 0;
  int a_prev = -1;
  always @(negedge clk) begin
    if (a_valid_in) begin
      if (exp_a.size() == 0) chk("a_unexpected_pkt", {a_source_in, a_target_in, a_data_in}, 32'hFFFF_FFFF);
      else chk("a_pkt", {a_source_in, a_target_in, a_data_in}, exp_a.pop_front());
      if (spacing_on) begin
        if (a_prev >= 0) chk("a_spacing", cyc - a_prev, 2);
        a_prev = cyc;
      end
    end else begin
      chk("a_idle_fields", {a_source_in, a_target_in, a_data_in}, 0);
    end
  end

  int b_run = 0;
  int b_max_run = 0;
  always @(negedge clk) begin
    if (b_valid_in) begin
      b_run++;
      if (b_run > b_max_run) b_max_run = b_run;
      if (exp_b.size() == 0) chk("b_unexpected_pkt", {b_source_in, b_target_in, b_data_in}, 32'hFFFF_FFFF);
      else chk("b_pkt", {b_source_in, b_target_in, b_data_in}, exp_b.pop_front());
    end else begin
      b_run = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit sel, input logic [3:0] t, input logic [7:0] d, input bit legal);
    bit   hs;
    logic rdy;
    @(negedge clk);
    if (sel) begin b_valid = 1; b_target = t; b_data = d; end
    else     begin a_valid = 1; a_target = t; a_data = d; end
    hs = 0;
    for (int i = 0; i < 200; i++) begin
      rdy = sel ? b_req_ready : a_req_ready;
      if (rdy) begin
        if (legal) begin
          if (sel) exp_b.push_back({OWN, t, d});
          else     exp_a.push_back({OWN, t, d});
        end
        @(posedge clk);
        hs = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    if (sel) b_valid = 0; else a_valid = 0;
    chk("handshake", 32'(hs), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;

    // 1: reset values, then ready one cycle after release
    repeat (3) @(negedge clk);
    chk("rst_valid_in", a_valid_in, 0);
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_sent", a_sent_cnt, 0);
    chk("rst_drop", a_drop_cnt, 0);
    chk("rst_state", a_state, 0);
    chk("rst_b_ready", b_req_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("rel_req_ready", a_req_ready, 1);
    chk("rel_busy", a_busy, 0);
    chk("rel_b_ready", b_req_ready, 1);

    // 2: single packet latency and fields
    a_enable = 1;
    drive(0, 4'b0100, 8'hA5, 1);
    @(negedge clk);
    chk("lat_early", a_valid_in, 0);
    @(negedge clk);
    chk("lat_valid", a_valid_in, 1);
    chk("lat_sent", a_sent_cnt, 1);
    repeat (4) @(negedge clk);

    // 3: illegal targets are handshaken and dropped
    do_reset();
    drive(0, 4'b0110, 8'h11, 0);
    drive(0, 4'b0000, 8'h22, 0);
    drive(0, 4'b0010, 8'h33, 0);
    repeat (5) @(negedge clk);
    chk("drop_cnt3", a_drop_cnt, 3);
    chk("sent_after_drop", a_sent_cnt, 0);
    chk("busy_after_drop", a_busy, 0);

    // 4: fill with enable low, 5th held off, then FIFO order with one-cycle gaps
    a_enable = 0;
    spacing_on = 1;
    a_prev = -1;
    for (int i = 1; i <= 4; i++) drive(0, 4'b0001, 8'(i), 1);
    fork
      drive(0, 4'b0001, 8'd5, 1);
      begin
        repeat (5) @(negedge clk) chk("full_ready_low", a_req_ready, 0);
        chk("full_busy", a_busy, 1);
        a_enable = 1;
      end
    join
    repeat (15) @(negedge clk);
    spacing_on = 0;
    chk("sent_after_5", a_sent_cnt, 5);
    chk("drop_still3", a_drop_cnt, 3);

    // 5: GAP=0 back-to-back
    b_enable = 0;
    drive(1, 4'b0100, 8'hC1, 1);
    drive(1, 4'b1000, 8'hC2, 1);
    drive(1, 4'b0001, 8'hC3, 1);
    @(negedge clk);
    chk("b_held", b_valid_in, 0);
    b_enable = 1;
    repeat (8) @(negedge clk);
    chk("b_run3", b_max_run, 3);
    chk("b_sent3", b_sent_cnt, 3);

    // 6: reset during the first SEND discards the rest
    a_enable = 0;
    drive(0, 4'b1000, 8'h61, 1);
    drive(0, 4'b0100, 8'h62, 1);
    @(negedge clk);
    a_enable = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_valid_in) begin seen = 1; break; end
    end
    chk("t6_first_send", 32'(seen), 1);
    #1;
    rst = 1;
    exp_a.delete();
    @(negedge clk);
    chk("t6_valid_off", a_valid_in, 0);
    chk("t6_sent0", a_sent_cnt, 0);
    chk("t6_drop0", a_drop_cnt, 0);
    chk("t6_busy0", a_busy, 0);
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("t6_no_more_sent", a_sent_cnt, 0);

    chk("exp_a_empty", exp_a.size(), 0);
    chk("exp_b_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
